// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-requester SRAM arbiter: FSM state encoding
// and requester index constants.
package sram_arb_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } state_e;

   // Requester indices into the two-bit request/grant vectors.
   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;

endpackage : sram_arb_pkg

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one-hot grant from a two-bit request vector,
// with a last-granted pointer that flips priority after every grant.
module rr_arbiter2
   import sram_arb_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);

   logic last_q;
   logic last_d;

   // NOTE: every output of a combinational block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      o_gnt = '0;
      if (i_en) begin
         if (i_req[REQ_A] && i_req[REQ_B]) begin
            // Tie: the requester not granted most recently wins.
            if (last_q == REQ_B) begin
               o_gnt[REQ_A] = 1'b1;
            end else begin
               o_gnt[REQ_B] = 1'b1;
            end
         end else begin
            o_gnt = i_req;
         end
      end
   end

   always_comb begin
      last_d = last_q;
      if (o_gnt[REQ_A]) begin
         last_d = REQ_A;
      end else if (o_gnt[REQ_B]) begin
         last_d = REQ_B;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from before the edge, independent of block order.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         last_q <= REQ_B;
      end else begin
         last_q <= last_d;
      end
   end

endmodule : rr_arbiter2

// File: rtl/sram_arbiter.sv
// Shares one single-port SRAM between two requesters: writes complete in the
// grant cycle, reads return two cycles after grant on the requester's port.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,

   input  logic                  i_a_req,
   input  logic                  i_a_write,
   input  logic [ADDR_WIDTH-1:0] i_a_addr,
   input  logic [DATA_WIDTH-1:0] i_a_data,
   output logic                  o_a_gnt,
   output logic                  o_a_rvalid,
   output logic [DATA_WIDTH-1:0] o_a_rdata,

   input  logic                  i_b_req,
   input  logic                  i_b_write,
   input  logic [ADDR_WIDTH-1:0] i_b_addr,
   input  logic [DATA_WIDTH-1:0] i_b_data,
   output logic                  o_b_gnt,
   output logic                  o_b_rvalid,
   output logic [DATA_WIDTH-1:0] o_b_rdata,

   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic                  o_mem_write,
   output logic [DATA_WIDTH-1:0] o_mem_data,
   input  logic [DATA_WIDTH-1:0] i_mem_data
);

   state_e                state_q,    state_d;
   logic                  rd_who_q,   rd_who_d;
   logic                  a_rvalid_q, a_rvalid_d;
   logic                  b_rvalid_q, b_rvalid_d;
   logic [DATA_WIDTH-1:0] a_rdata_q,  a_rdata_d;
   logic [DATA_WIDTH-1:0] b_rdata_q,  b_rdata_d;

   logic [1:0] req;
   logic [1:0] gnt;
   logic       arb_en;

   assign req[REQ_A] = i_a_req;
   assign req[REQ_B] = i_b_req;

   // Grants only happen in IDLE and never while reset is held.
   assign arb_en = (state_q == IDLE) && !i_rst;

   rr_arbiter2 u_arb (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_en  (arb_en),
      .i_req (req),
      .o_gnt (gnt)
   );

   assign o_a_gnt = gnt[REQ_A];
   assign o_b_gnt = gnt[REQ_B];

   always_comb begin
      state_d     = state_q;
      rd_who_d    = rd_who_q;
      o_mem_addr  = '0;
      o_mem_write = 1'b0;
      o_mem_data  = '0;

      unique case (state_q)
         IDLE: begin
            if (gnt[REQ_A]) begin
               o_mem_addr  = i_a_addr;
               o_mem_write = i_a_write;
               o_mem_data  = i_a_data;
               if (!i_a_write) begin
                  state_d  = RD_WAIT;
                  rd_who_d = REQ_A;
               end
            end else if (gnt[REQ_B]) begin
               o_mem_addr  = i_b_addr;
               o_mem_write = i_b_write;
               o_mem_data  = i_b_data;
               if (!i_b_write) begin
                  state_d  = RD_WAIT;
                  rd_who_d = REQ_B;
               end
            end
         end
         RD_WAIT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // SRAM data is valid during RD_WAIT; capture it for the owner of the read.
   always_comb begin
      a_rvalid_d = (state_q == RD_WAIT) && (rd_who_q == REQ_A);
      b_rvalid_d = (state_q == RD_WAIT) && (rd_who_q == REQ_B);
      a_rdata_d  = a_rvalid_d ? i_mem_data : a_rdata_q;
      b_rdata_d  = b_rvalid_d ? i_mem_data : b_rdata_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= IDLE;
         rd_who_q   <= REQ_A;
         a_rvalid_q <= 1'b0;
         b_rvalid_q <= 1'b0;
         a_rdata_q  <= '0;
         b_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         rd_who_q   <= rd_who_d;
         a_rvalid_q <= a_rvalid_d;
         b_rvalid_q <= b_rvalid_d;
         a_rdata_q  <= a_rdata_d;
         b_rdata_q  <= b_rdata_d;
      end
   end

   assign o_a_rvalid = a_rvalid_q;
   assign o_b_rvalid = b_rvalid_q;
   assign o_a_rdata  = a_rdata_q;
   assign o_b_rdata  = b_rdata_q;

endmodule : sram_arbiter

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, SRAM address width in bits.
REQ-002 Parameter DATA_WIDTH, default 32, SRAM data width in bits.
REQ-003 i_clk  input  1  single clock, all logic on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_a_req  input  1  requester A access request, held until granted.
REQ-006 i_a_write  input  1  requester A access type: 1 = write, 0 = read.
REQ-007 i_a_addr  input  ADDR_WIDTH  requester A address.
REQ-008 i_a_data  input  DATA_WIDTH  requester A write data.
REQ-009 o_a_gnt  output  1  one-cycle pulse; requester A access accepted this cycle.
REQ-010 o_a_rvalid  output  1  one-cycle pulse; o_a_rdata holds requester A read result.
REQ-011 o_a_rdata  output  DATA_WIDTH  requester A read data.
REQ-012 i_b_req, i_b_write, i_b_addr, i_b_data, o_b_gnt, o_b_rvalid, o_b_rdata: same widths and meanings as REQ-005..011, for requester B.
REQ-013 o_mem_addr  output  ADDR_WIDTH  SRAM address.
REQ-014 o_mem_write  output  1  SRAM write enable.
REQ-015 o_mem_data  output  DATA_WIDTH  SRAM write data.
REQ-016 i_mem_data  input  DATA_WIDTH  SRAM read data, valid one cycle after the read address is presented.

Function
REQ-017 FSM states: IDLE (may grant) and RD_WAIT (read outstanding, no grant).
REQ-018 In IDLE, with at least one request, exactly one o_x_gnt asserts combinationally in that cycle (cycle T).
REQ-019 In cycle T, o_mem_addr, o_mem_write and o_mem_data are driven from the granted requester.
REQ-020 Arbitration: single request is granted. If both request, grant the requester not granted most recently. After reset the last-granted pointer is B, so A wins the first tie.
REQ-021 Last-granted pointer updates at the end of every grant cycle.
REQ-022 Write grant: o_mem_write=1 in T only; FSM stays IDLE; a new grant is allowed in T+1. Writes sustain one per cycle.
REQ-023 Read grant: o_mem_write=0 in T; FSM enters RD_WAIT for T+1.
REQ-024 In T+1, i_mem_data is registered into the granted requester's o_x_rdata. The matching o_x_rvalid is 1 in T+2 for exactly one cycle.
REQ-025 Read latency from grant to rvalid is 2 cycles. Reads sustain one per 2 cycles.
REQ-026 RD_WAIT always returns to IDLE after one cycle. A grant may occur in T+2, the same cycle rvalid is high.
REQ-027 When not granting: o_mem_write=0, o_mem_addr=0, o_mem_data=0.
REQ-028 o_x_rdata holds its value until the next read for that requester completes.
REQ-029 A request deasserted before grant is dropped with no side effects. Req, write, addr and data must be stable from assertion to grant.
REQ-030 Unless the other requester is idle, a requester is never granted twice in a row while the other is requesting. Maximum wait is one access.

Reset
REQ-031 On i_rst=1 at a clock edge: FSM=IDLE, pointer=B, o_a_rvalid=o_b_rvalid=0, o_a_rdata=o_b_rdata=0.
REQ-032 While i_rst=1, all o_x_gnt=0 and o_mem_write=0.
REQ-033 Reset during RD_WAIT discards the outstanding read. No rvalid appears after reset.

Structure
REQ-034 Shared package sram_arb_pkg holds the FSM state encoding (IDLE, RD_WAIT) and the requester index constants (REQ_A=0, REQ_B=1).
REQ-035 A single sub-module rr_arbiter2 (2-way round-robin: request in, one-hot grant out, pointer register) provides the arbitration. The FSM and datapath live in sram_arbiter.

Verification
REQ-036 A writes addr 3 data 0xDEADBEEF, then reads addr 3: o_a_gnt pulses on each access; o_a_rvalid is high 2 cycles after the read grant with o_a_rdata=0xDEADBEEF.
REQ-037 A and B request reads in the same cycle after reset: A is granted at T; B is granted at T+2; o_a_rvalid at T+2; o_b_rvalid at T+4; no cross-delivery.
REQ-038 A and B both hold write requests for 6 cycles: grants alternate A,B,A,B,A,B, one per cycle; o_mem_write is high every cycle.
REQ-039 i_rst asserted in the RD_WAIT cycle of an A read: no o_a_rvalid follows; all outputs return to reset values; the next request is granted normally.
REQ-040 B writes addr 15 (wrap boundary) data 0x00000001 and A reads addr 15 back: o_a_rdata=0x00000001. While no request is pending, o_mem_write=0 and o_mem_addr=0.
